logshift_pipe: RTL and testbench

LOGSHIFT_PIPE -- requirements
Module: logshift_pipe

---
 rtl/logshift_pkg.sv | 53 +++++
 rtl/logshift_pipe_if.sv | 65 ++++++
 rtl/logshift_stage.sv | 89 ++++++++
 rtl/logshift_pipe.sv | 100 ++++++++++
 tb/tb_logshift_pipe.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/logshift_pkg.sv
// -----------------------------------------------------------------------------
// logshift_pkg
//
// Purpose:
//   Shared definitions for the pipelined logarithmic shifter (logshift_pipe).
//   Holds the shift-mode encodings, the per-stage pipeline record and a small
//   helper used by the stages to decide when shifted-out bits are tracked.
//
// Ports:
//   none (package)
//
// Configuration:
//   LOGSHIFT_PIPE_STICKY_EN - when defined, the stage record carries a sticky
//                             bit (OR of all bits shifted out so far).
// -----------------------------------------------------------------------------
package logshift_pkg;

    // The stage record has to be a fixed type because packages cannot be
    // parameterised. Fields are therefore sized for the widest legal
    // configuration (WIDTH=64). Narrower builds use only the low bits and
    // keep the upper bits at zero.
    localparam int MAX_WIDTH = 64;
    localparam int MAX_LOG2W = 6;

    // Shift-mode encodings as they appear on the mode input.
    typedef enum logic [1:0] {
        MODE_LSR = 2'b00,   // logical right, zero fill
        MODE_ASR = 2'b01,   // arithmetic right, sign fill
        MODE_LSL = 2'b10,   // logical left, zero fill
        MODE_ROR = 2'b11    // rotate right
    } shift_mode_e;

    // One pipeline slot. Every stage register holds one of these, so a beat
    // travels together with its remaining shift amount and its mode. Bubbles
    // are simply records with valid=0.
    typedef struct packed {
        logic                   valid;
        logic [MAX_WIDTH-1:0]   data;
        logic [MAX_LOG2W-1:0]   sh;
        shift_mode_e            mode;
`ifdef LOGSHIFT_PIPE_STICKY_EN
        logic                   sticky;
`endif
    } stage_rec_t;

    // Bits that leave the word are only "lost" in the two right-shift modes.
    // A left shift discards bits at the top, and a rotate loses nothing, so
    // neither contributes to sticky.
    function automatic logic is_right_mode(input shift_mode_e m);
        return (m == MODE_LSR) || (m == MODE_ASR);
    endfunction

endpackage

// File: rtl/logshift_pipe_if.sv
// -----------------------------------------------------------------------------
// logshift_pipe_if
//
// Purpose:
//   Bundles the operand handshake (producer side) and the result handshake
//   (consumer side) of logshift_pipe into one interface.
//
// Signals:
//   in_valid  - producer presents an operand this cycle
//   in_ready  - pipeline accepts an operand this cycle
//   a         - operand, WIDTH bits
//   sh        - unsigned shift amount, LOG2W bits
//   mode      - 00 LSR, 01 ASR, 10 LSL, 11 ROR
//   out_valid - dataout holds a result
//   out_ready - consumer takes the result this cycle
//   dataout   - shifted result, WIDTH bits
//   sticky    - OR of all bits shifted out (only with LOGSHIFT_PIPE_STICKY_EN)
//
// Modports:
//   master - the environment (drives operands, consumes results)
//   slave  - the shifter itself
//
// Configuration:
//   LOGSHIFT_PIPE_STICKY_EN - adds the sticky signal.
// -----------------------------------------------------------------------------
interface logshift_pipe_if #(
    parameter int WIDTH = 16
);
    localparam int LOG2W = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [LOG2W-1:0] sh;
    logic [1:0]       mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] dataout;
`ifdef LOGSHIFT_PIPE_STICKY_EN
    logic             sticky;
`endif

`ifdef LOGSHIFT_PIPE_STICKY_EN
    modport master (
        output in_valid, a, sh, mode, out_ready,
        input  in_ready, out_valid, dataout, sticky
    );

    modport slave (
        input  in_valid, a, sh, mode, out_ready,
        output in_ready, out_valid, dataout, sticky
    );
`else
    modport master (
        output in_valid, a, sh, mode, out_ready,
        input  in_ready, out_valid, dataout
    );

    modport slave (
        input  in_valid, a, sh, mode, out_ready,
        output in_ready, out_valid, dataout
    );
`endif

endinterface

// File: rtl/logshift_stage.sv
// -----------------------------------------------------------------------------
// logshift_stage
//
// Purpose:
//   One stage of the logarithmic shifter. If bit K of the carried shift
//   amount is set, the data is shifted by 2^K in the carried mode; otherwise
//   it passes unchanged. The result is registered when 'advance' is high.
//
// Parameters:
//   WIDTH - data width (power of two, 4..64)
//   K     - stage index; this stage handles a shift of 2^K
//
// Ports:
//   clk     - clock, rising edge
//   reset   - asynchronous, active-high reset; clears the whole record
//   advance - global pipeline enable (low = stall, hold the register)
//   din     - record from the previous stage (or the input of the pipe)
//   dout    - registered record for the next stage
//
// Configuration:
//   LOGSHIFT_PIPE_STICKY_EN - accumulate the sticky bit in right-shift modes.
// -----------------------------------------------------------------------------
module logshift_stage
    import logshift_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int K     = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       advance,
    input  stage_rec_t din,
    output stage_rec_t dout
);

    // Fixed shift distance of this stage. At most WIDTH/2, so the rotate
    // term below never needs a shift of WIDTH or more.
    localparam int AMT = 1 << K;

    logic        [WIDTH-1:0] d_in;
    logic signed [WIDTH-1:0] d_signed;
    logic        [WIDTH-1:0] d_shift;
    stage_rec_t              rec_next;

    // Shift datapath. All four candidate shifts are by a constant, so this is
    // just wiring plus a 4:1 mux per bit. For the arithmetic case, the MSB at
    // this point is still the original sign because every earlier ASR stage
    // refilled with that same bit. Everything except data (and sticky) passes
    // through untouched; the full sh value rides along and each stage simply
    // looks at its own bit.
    always_comb begin
        d_in     = din.data[WIDTH-1:0];
        d_signed = d_in;
        d_shift  = d_in;
        rec_next = din;

        case (din.mode)
            MODE_LSR: d_shift = d_in >> AMT;
            MODE_ASR: d_shift = d_signed >>> AMT;
            MODE_LSL: d_shift = d_in << AMT;
            MODE_ROR: d_shift = (d_in >> AMT) | (d_in << (WIDTH - AMT));
            default:  d_shift = d_in;
        endcase

        if (din.sh[K]) begin
            rec_next.data[WIDTH-1:0] = d_shift;
        end

`ifdef LOGSHIFT_PIPE_STICKY_EN
        // The low AMT bits are the ones falling off the bottom in a right
        // shift. Left shifts and rotates never set sticky.
        if (din.sh[K] && is_right_mode(din.mode)) begin
            rec_next.sticky = din.sticky | (|d_in[AMT-1:0]);
        end
`endif
    end

    // Pipeline register. All stages share the same 'advance', which makes a
    // stall global: the whole pipe freezes, bubbles included, so the relative
    // spacing of beats never changes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout <= '0;
        end else if (advance) begin
            dout <= rec_next;
        end
    end

endmodule

// File: rtl/logshift_pipe.sv
// -----------------------------------------------------------------------------
// logshift_pipe
//
// Purpose:
//   Pipelined logarithmic barrel shifter with a valid/ready stream interface.
//   LOG2W registered stages; stage k conditionally shifts by 2^k, lowest stage
//   first. Latency is exactly LOG2W cycles when the consumer does not stall,
//   and throughput is one operand per cycle.
//
// Parameters:
//   WIDTH - data width, power of two from 4 to 64 (default 16)
//   LOG2W - (localparam) clog2(WIDTH): shift-amount width and stage count
//
// Ports:
//   clk   - clock, all state changes on the rising edge
//   reset - asynchronous, active-high reset; discards every beat in flight
//   bus   - logshift_pipe_if.slave:
//             in_valid/in_ready/a/sh/mode    operand handshake
//             out_valid/out_ready/dataout    result handshake
//             sticky                         only with LOGSHIFT_PIPE_STICKY_EN
//
// Configuration:
//   LOGSHIFT_PIPE_STICKY_EN - when defined, each stage carries a sticky bit and
//                             the final one drives bus.sticky. When undefined,
//                             neither the port nor the registers exist.
// -----------------------------------------------------------------------------
module logshift_pipe
    import logshift_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic           clk,
    input  logic           reset,
    logshift_pipe_if.slave bus
);

    localparam int LOG2W = $clog2(WIDTH);

    stage_rec_t rec_in;
    stage_rec_t stage_q [LOG2W];
    logic       advance;

    // The pipe moves as one unit. It may move whenever the output slot is
    // empty or is being taken this cycle; that same condition is in_ready.
    // An empty output slot frees the pipe even with bubbles further up, so
    // bubbles are never squeezed out and the timing of beats is preserved.
    assign advance      = !stage_q[LOG2W-1].valid || bus.out_ready;
    assign bus.in_ready = advance;

    // Pack the incoming operand into a stage record. When in_valid is low the
    // record is a bubble; it still enters stage 0 on an advance so that the
    // stage behind it does not hold a stale copy of the previous beat.
    // Upper bits beyond WIDTH/LOG2W stay zero.
    always_comb begin
        rec_in                    = '0;
        rec_in.valid              = bus.in_valid;
        rec_in.data[WIDTH-1:0]    = bus.a;
        rec_in.sh[LOG2W-1:0]      = bus.sh;
        rec_in.mode               = shift_mode_e'(bus.mode);
    end

    // Chain of LOG2W stages. Stage 0 takes the packed input, every later stage
    // takes the register output of its predecessor.
    for (genvar k = 0; k < LOG2W; k++) begin : g_stage
        if (k == 0) begin : g_first
            logshift_stage #(
                .WIDTH (WIDTH),
                .K     (k)
            ) u_stage (
                .clk     (clk),
                .reset   (reset),
                .advance (advance),
                .din     (rec_in),
                .dout    (stage_q[k])
            );
        end else begin : g_rest
            logshift_stage #(
                .WIDTH (WIDTH),
                .K     (k)
            ) u_stage (
                .clk     (clk),
                .reset   (reset),
                .advance (advance),
                .din     (stage_q[k-1]),
                .dout    (stage_q[k])
            );
        end
    end

    // The last stage register is the output slot. While out_valid=1 and
    // out_ready=0, advance is low, so this register and therefore dataout
    // and out_valid hold steady.
    assign bus.out_valid = stage_q[LOG2W-1].valid;
    assign bus.dataout   = stage_q[LOG2W-1].data[WIDTH-1:0];

`ifdef LOGSHIFT_PIPE_STICKY_EN
    assign bus.sticky    = stage_q[LOG2W-1].sticky;
`endif

endmodule

// File: tb/tb_logshift_pipe.sv
// -----------------------------------------------------------------------------
// tb_logshift_pipe
//
// Purpose:
//   Self-checking bench for logshift_pipe at WIDTH=16. Directed vectors with
//   hand-computed results, back-to-back streams, a consumer stall and a
//   mid-flight reset. Sticky checks are included when LOGSHIFT_PIPE_STICKY_EN
//   is defined.
// -----------------------------------------------------------------------------
module tb_logshift_pipe;

    localparam int WIDTH = 16;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    int nVectors     = 0;
    int nMiscompares = 0;

    logic [15:0] expQ [$];

    logshift_pipe_if #(.WIDTH(WIDTH)) bus ();

    logshift_pipe #(
        .WIDTH (WIDTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    // Safety net so the run always ends even if the DUT never responds.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point: counts every comparison, reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        nVectors++;
        if (observed !== expected) begin
            nMiscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Advance one clock and settle just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bit-by-bit reference of the four shift modes.
    function automatic logic [15:0] refShift(input logic [15:0] a, input logic [3:0] s,
                                             input logic [1:0] m);
        logic [15:0] r;
        int si;
        si = int'(s);
        r  = '0;
        for (int i = 0; i < 16; i++) begin
            case (m)
                2'b00:   r[i] = (i + si < 16) ? a[(i + si) % 16] : 1'b0;
                2'b01:   r[i] = (i + si < 16) ? a[(i + si) % 16] : a[15];
                2'b10:   r[i] = (i >= si) ? a[(i - si + 16) % 16] : 1'b0;
                default: r[i] = a[(i + si) % 16];
            endcase
        end
        return r;
    endfunction

    // One isolated beat: check acceptance, latency, result, sticky and that
    // out_valid lasts exactly one cycle.
    task automatic applyStimulus(input string tag, input logic [15:0] a, input logic [3:0] s,
                                 input logic [1:0] m, input logic [15:0] expData,
                                 input logic expSticky);
        int waitN;
        bus.out_ready = 1'b1;
        checkOutput({tag, "_in_ready"}, 32'(bus.in_ready), 1);
        bus.in_valid = 1'b1;
        bus.a        = a;
        bus.sh       = s;
        bus.mode     = m;
        tick();
        bus.in_valid = 1'b0;
        bus.a        = '0;
        bus.sh       = '0;
        bus.mode     = '0;
        waitN = 1;
        while (!bus.out_valid && waitN < 12) begin
            tick();
            waitN++;
        end
        checkOutput({tag, "_latency"}, 32'(waitN), 4);
        checkOutput({tag, "_data"}, 32'(bus.dataout), 32'(expData));
`ifdef LOGSHIFT_PIPE_STICKY_EN
        checkOutput({tag, "_sticky"}, 32'(bus.sticky), 32'(expSticky));
`else
        if (expSticky === 1'bz) $display("[TB] sticky not built");
`endif
        tick();
        checkOutput({tag, "_pulse"}, 32'(bus.out_valid), 0);
    endtask

    // Back-to-back stream with out_ready held high. Outputs are sampled before
    // new inputs are driven in each cycle.
    task automatic runStream(input string tag, input int n, input bit mixed);
        int got;
        int firstCycle;
        int lastCycle;
        logic [15:0] a;
        logic [3:0]  s;
        logic [1:0]  m;
        got        = 0;
        firstCycle = -1;
        lastCycle  = -1;
        expQ.delete();
        bus.out_ready = 1'b1;
        for (int c = 0; c < n + 12; c++) begin
            if (bus.out_valid) begin
                if (expQ.size() == 0) begin
                    checkOutput({tag, "_spurious"}, 32'(bus.out_valid), 0);
                end else begin
                    checkOutput({tag, "_data"}, 32'(bus.dataout), 32'(expQ.pop_front()));
                    got++;
                    if (firstCycle < 0) firstCycle = c;
                    lastCycle = c;
                end
            end
            if (c < n) begin
                if (mixed) begin
                    a = 16'(16'hA5C3 ^ (c * 16'h1357));
                    s = 4'(c * 3);
                    m = 2'(c);
                end else begin
                    a = 16'(c);
                    s = 4'(c);
                    m = 2'b00;
                end
                checkOutput({tag, "_in_ready"}, 32'(bus.in_ready), 1);
                bus.in_valid = 1'b1;
                bus.a        = a;
                bus.sh       = s;
                bus.mode     = m;
                expQ.push_back(refShift(a, s, m));
            end else begin
                bus.in_valid = 1'b0;
            end
            tick();
        end
        checkOutput({tag, "_count"}, 32'(got), 32'(n));
        checkOutput({tag, "_first"}, 32'(firstCycle), 4);
        checkOutput({tag, "_span"}, 32'(lastCycle - firstCycle + 1), 32'(n));
    endtask

    // Fill the pipe with the consumer stalled, hold 5 cycles, then drain.
    task automatic runStall();
        int got;
        logic [15:0] a;
        logic [3:0]  s;
        logic [1:0]  m;
        expQ.delete();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a = 16'(16'hC3A5 ^ (i * 16'h0111));
            s = 4'(i + 1);
            m = 2'(i);
            checkOutput("stall_fill_ready", 32'(bus.in_ready), 1);
            bus.in_valid = 1'b1;
            bus.a        = a;
            bus.sh       = s;
            bus.mode     = m;
            expQ.push_back(refShift(a, s, m));
            tick();
        end
        bus.in_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            checkOutput("stall_in_ready", 32'(bus.in_ready), 0);
            checkOutput("stall_valid", 32'(bus.out_valid), 1);
            checkOutput("stall_data", 32'(bus.dataout), 32'(expQ[0]));
            tick();
        end
        bus.out_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 12; c++) begin
            if (bus.out_valid) begin
                if (expQ.size() == 0) begin
                    checkOutput("stall_spurious", 32'(bus.out_valid), 0);
                end else begin
                    checkOutput("stall_drain", 32'(bus.dataout), 32'(expQ.pop_front()));
                    got++;
                end
            end
            tick();
        end
        checkOutput("stall_count", 32'(got), 4);
    endtask

    // Three beats in flight, reset for one cycle; none may ever come out.
    task automatic runReset();
        int seen;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.a        = 16'(16'h5555 + i);
            bus.sh       = 4'd1;
            bus.mode     = 2'b10;
            tick();
        end
        bus.in_valid = 1'b0;
        tick();
        checkOutput("rst_pre_valid", 32'(bus.out_valid), 1);
        reset = 1'b1;
        #1;
        checkOutput("rst_out_valid", 32'(bus.out_valid), 0);
        checkOutput("rst_dataout", 32'(bus.dataout), 0);
        checkOutput("rst_in_ready", 32'(bus.in_ready), 1);
        tick();
        reset = 1'b0;
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            if (bus.out_valid) seen++;
            tick();
        end
        checkOutput("rst_no_ghost", 32'(seen), 0);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.sh        = '0;
        bus.mode      = '0;
        bus.out_ready = 1'b1;
        reset         = 1'b1;
        tick();
        tick();
        checkOutput("reset_out_valid", 32'(bus.out_valid), 0);
        checkOutput("reset_dataout", 32'(bus.dataout), 0);
        checkOutput("reset_in_ready", 32'(bus.in_ready), 1);
`ifdef LOGSHIFT_PIPE_STICKY_EN
        checkOutput("reset_sticky", 32'(bus.sticky), 0);
`endif
        reset = 1'b0;
        tick();
        checkOutput("post_reset_out_valid", 32'(bus.out_valid), 0);

        applyStimulus("asr1",      16'h8001, 4'd1,  2'b01, 16'hC000, 1'b1);
        applyStimulus("ror15",     16'h8001, 4'd15, 2'b11, 16'h0003, 1'b0);
        applyStimulus("lsl15",     16'h8001, 4'd15, 2'b10, 16'h8000, 1'b0);
        applyStimulus("lsr4",      16'h00F0, 4'd4,  2'b00, 16'h000F, 1'b0);
        applyStimulus("lsr5",      16'h00F0, 4'd5,  2'b00, 16'h0007, 1'b1);
        applyStimulus("asr0",      16'hB6E1, 4'd0,  2'b01, 16'hB6E1, 1'b0);
        applyStimulus("ror0",      16'hB6E1, 4'd0,  2'b11, 16'hB6E1, 1'b0);
        applyStimulus("asr15neg",  16'h8000, 4'd15, 2'b01, 16'hFFFF, 1'b0);
        applyStimulus("asr15pos",  16'h7FFF, 4'd15, 2'b01, 16'h0000, 1'b1);
        applyStimulus("lsr15",     16'hFFFF, 4'd15, 2'b00, 16'h0001, 1'b1);
        applyStimulus("ror4",      16'h1234, 4'd4,  2'b11, 16'h4123, 1'b0);
        applyStimulus("lsl8",      16'h1234, 4'd8,  2'b10, 16'h3400, 1'b0);
        applyStimulus("lsl15one",  16'h0001, 4'd15, 2'b10, 16'h8000, 1'b0);

        runStream("stream", 8, 1'b0);
        runStream("mixed", 12, 1'b1);
        runStall();
        runReset();

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
